fetch_stage: RTL and testbench

//  Instruction-fetch stage upstream of the decode controller. Holds the PC and issues
//  req/ack reads to instruction memory. Drives the IF/ID pipeline register.
//  Its if_id_inst[6:0] is the Opcode input of the decode controller.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_skid_buf.sv | 39 +++
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcodes, the canonical NOP word and
// the fetch FSM state type. Imported by the fetch_stage files.
package riscv_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, inst} holding buffer for words returned while decode stalls.
// Ports: clk, reset (sync, high), push/pop/clear, push_pc/push_inst in; full, pc, inst out.
module fetch_skid_buf #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [PC_W-1:0] push_pc,
  input  logic [31:0]     push_inst,
  output logic            full,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     inst
);
  import riscv_pkg::*;

  // push wins over pop so a simultaneous pop+push leaves the new word held
  always_ff @(posedge clk) begin
    if (reset || clear)
      full <= 1'b0;
    else if (push)
      full <= 1'b1;
    else if (pop)
      full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc   <= '0;
      inst <= NOP_INST;
    end else if (push && !clear) begin
      pc   <= push_pc;
      inst <= push_inst;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, req/ack imem FSM, skid buffer and IF/ID register.
// Ports: clk, reset, stall, redirect_*, imem_* handshake, if_id_* outputs.
// Define FETCH_PERF_EN to add perf_fetched / perf_bubbles saturating counters.
module fetch_stage #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [PC_W-1:0] if_id_pc,
  output logic [31:0]     if_id_inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubbles
`endif
);
  import riscv_pkg::*;

  fetch_state_t    state;
  logic [PC_W-1:0] pc;

  logic            skid_full;
  logic [PC_W-1:0] skid_pc;
  logic [31:0]     skid_inst;
  logic            ack_data;
  logic            skid_push;
  logic            skid_pop;
  logic            wr_valid;

  // ack in the redirect cycle belongs to the squashed path
  assign ack_data  = (state == WAIT) && imem_ack
                   && !redirect_valid;
  assign skid_pop  = !redirect_valid && !stall
                   && skid_full;
  // skid drains first, so a same-cycle ack lands in the skid
  assign skid_push = ack_data && (stall || skid_full);
  assign wr_valid  = !redirect_valid && !stall
                   && (skid_full || ack_data);

  assign imem_req = (state != IDLE);

  fetch_skid_buf #(
    .PC_W(PC_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (skid_push),
    .pop      (skid_pop),
    .clear    (redirect_valid),
    .push_pc  (imem_addr),
    .push_inst(imem_rdata),
    .full     (skid_full),
    .pc       (skid_pc),
    .inst     (skid_inst)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
    end else begin
      unique case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (!skid_full) begin
            state     <= WAIT;
            imem_addr <= pc;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= imem_ack ? IDLE : DISCARD;
          end else if (imem_ack) begin
            pc    <= pc + PC_W'(4);
            state <= IDLE;
          end
        end
        DISCARD: begin
          if (redirect_valid)
            pc <= redirect_pc;
          if (imem_ack)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_inst  <= NOP_INST;
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
    end else if (!stall) begin
      if (skid_full) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= skid_pc;
        if_id_inst  <= skid_inst;
      end else if (ack_data) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= imem_addr;
        if_id_inst  <= imem_rdata;
      end else begin
        if_id_valid <= 1'b0;
        if_id_inst  <= NOP_INST;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (wr_valid && perf_fetched != '1)
        perf_fetched <= perf_fetched + 32'd1;
      if (!stall && !wr_valid && perf_bubbles != '1)
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = wr_valid;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage with a transaction-level
// fetch-stream model, plus directed reset and PC wrap checks.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;

  logic        reset8;
  logic        ack8;
  logic        req8;
  logic [7:0]  addr8;
  logic        v8;
  logic [7:0]  pc8;
  logic [31:0] inst8;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
  logic [31:0] pf8, pb8;
`endif

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_inst    (if_id_inst)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_bubbles  (perf_bubbles)
`endif
  );

  fetch_stage #(
    .PC_W    (8),
    .RESET_PC(8'hFC)
  ) u8 (
    .clk           (clk),
    .reset         (reset8),
    .stall         (1'b0),
    .redirect_valid(1'b0),
    .redirect_pc   (8'h00),
    .imem_req      (req8),
    .imem_addr     (addr8),
    .imem_ack      (ack8),
    .imem_rdata    (32'h00A00093),
    .if_id_valid   (v8),
    .if_id_pc      (pc8),
    .if_id_inst    (inst8)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (pf8),
    .perf_bubbles  (pb8)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t exp_q[$];
  logic mon_en = 1'b0;

  // monitor: compares each instruction decode accepts against the queue
  logic        p_hold = 1'b0;
  logic        p_flush = 1'b0;
  logic        p_valid;
  logic [31:0] p_pc, p_inst;

  always @(negedge clk) begin
    ent_t e;
    #1;
    if (mon_en) begin
      if (p_hold) begin
        chk("hold_valid", {31'd0, if_id_valid}, {31'd0, p_valid});
        chk("hold_pc", if_id_pc, p_pc);
        chk("hold_inst", if_id_inst, p_inst);
      end
      if (p_flush) begin
        chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
        chk("flush_inst", if_id_inst, NOP_INST);
      end
      if (!if_id_valid) begin
        chk("bubble_inst", if_id_inst, NOP_INST);
      end else if (!stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst actual=%h/%h expected=none",
                   if_id_pc, if_id_inst);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", if_id_pc, e.pc);
          chk("inst_word", if_id_inst, e.inst);
        end
      end
      p_hold  = stall && !redirect_valid;
      p_flush = redirect_valid;
      p_valid = if_id_valid;
      p_pc    = if_id_pc;
      p_inst  = if_id_inst;
    end else begin
      p_hold  = 1'b0;
      p_flush = 1'b0;
    end
  end

  // stimulus: memory responder, stall/redirect and the fetch-stream model
  logic        txn;
  logic        drop;
  int          lat;
  logic [31:0] taddr;
  logic [31:0] fetch_pc;
  bit          ok;

  initial begin
    reset          = 1'b1;
    reset8         = 1'b1;
    ack8           = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    txn            = 1'b0;
    drop           = 1'b0;
    lat            = 0;
    taddr          = '0;
    fetch_pc       = '0;

    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_inst", if_id_inst, NOP_INST);
    reset  = 1'b0;
    mon_en = 1'b1;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (!txn && imem_req) begin
        chk("req_addr", imem_addr, fetch_pc);
        txn   = 1'b1;
        taddr = imem_addr;
        lat   = (cyc < 20) ? 0 : int'($urandom_range(2));
      end else if (txn) begin
        chk("addr_stable", imem_addr, taddr);
      end
      if (txn) begin
        if (lat == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = memw(taddr);
        end else begin
          lat--;
        end
      end
      if (cyc < 20) begin
        stall          = 1'b0;
        redirect_valid = 1'b0;
      end else begin
        stall          = ($urandom_range(99) < 30);
        redirect_valid = ($urandom_range(99) < 6);
        redirect_pc    = ($urandom_range(9) == 0) ? 32'hFFFFFFF8
                       : ($urandom & 32'h000003FF);
      end
      #2;
      if (redirect_valid) begin
        exp_q.delete();
        fetch_pc = redirect_pc;
        if (txn && !imem_ack) drop = 1'b1;
      end
      if (imem_ack) begin
        if (!redirect_valid && !drop) begin
          ent_t e;
          e.pc   = taddr;
          e.inst = memw(taddr);
          exp_q.push_back(e);
          fetch_pc = taddr + 32'd4;
        end
        txn  = 1'b0;
        drop = 1'b0;
      end
    end

    // reset in the middle of an outstanding request
    @(negedge clk);
    mon_en         = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_ack       = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (imem_req) ok = 1'b1;
    end
    chk("wait_req_seen", {31'd0, ok}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'd0);
    chk("mid_rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("mid_rst_inst", if_id_inst, NOP_INST);
`ifdef FETCH_PERF_EN
    chk("perf_fetched_rst", perf_fetched, 32'd0);
    chk("perf_bubbles_rst", perf_bubbles, 32'd0);
`endif
    reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_valid", {31'd0, if_id_valid}, 32'd0);
    chk("late_ack_inst", if_id_inst, NOP_INST);
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'd0);

    // 8-bit PC wraps from 0xFC to 0x00
    reset8 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5 && !ok; i++) begin
      @(negedge clk);
      if (req8) ok = 1'b1;
    end
    chk("w8_req_seen", {31'd0, ok}, 32'd1);
    chk("w8_addr_fc", {24'd0, addr8}, 32'h000000FC);
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0;
    chk("w8_valid", {31'd0, v8}, 32'd1);
    chk("w8_pc", {24'd0, pc8}, 32'h000000FC);
    chk("w8_inst", inst8, 32'h00A00093);
    ok = 1'b0;
    for (int i = 0; i < 5 && !ok; i++) begin
      @(negedge clk);
      if (req8) ok = 1'b1;
    end
    chk("w8_req2_seen", {31'd0, ok}, 32'd1);
    chk("w8_addr_wrap", {24'd0, addr8}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
